// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder: PS/2 keyboard frames to snake-game direction code
// Ports: clk/rst_n system clock and async active-low reset; ps2_clk_i/ps2_data_i raw PS/2 pins;
// direction_o game code (d=000 s=001 a=010 w=011 rst=100); scan_code_o last good byte;
// byte_valid_o pulse per good byte; frame_err_o pulse per start/parity/stop error or timeout.
module ps2_direction_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [2:0] direction_o,
  output logic [7:0] scan_code_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] clk_sync_q, dat_sync_q;
  logic filt_q, filt_d, fall_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, scan_code_q, scan_code_d;
  logic par_ok_q, par_ok_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic [2:0] dir_q, dir_d, mk;
  logic mk_ok, accept, din;
  assign din = dat_sync_q[1];
  always_comb begin
    filt_d = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = ~filt_q;
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    par_ok_d = par_ok_q;
    to_cnt_d = to_cnt_q;
    byte_valid_d = 1'b0;
    frame_err_d = 1'b0;
    scan_code_d = scan_code_q;
    if (fall_q) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          frame_err_d = din;
          state_d = din ? IDLE : DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, din};
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          byte_valid_d = din & par_ok_q;
          frame_err_d = ~(din & par_ok_q);
          scan_code_d = (din & par_ok_q) ? shift_q : scan_code_q;
        end
      endcase
    end else if (state_q != IDLE) begin
      // a fall in the same cycle takes priority over an expiring timeout
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        frame_err_d = 1'b1;
        to_cnt_d = '0;
      end else to_cnt_d = to_cnt_q + 1'b1;
    end
  end
  always_comb begin
    mk_ok = 1'b1;
    mk = 3'b100;
    case ({ext_q, scan_code_q})
      9'h01D, 9'h175: mk = 3'b011;
      9'h01C, 9'h16B: mk = 3'b010;
      9'h01B, 9'h172: mk = 3'b001;
      9'h023, 9'h174: mk = 3'b000;
      9'h029:         mk = 3'b100;
      default:        mk_ok = 1'b0;
    endcase
  end
  // opposite pairs w/s and a/d differ only in bit 1
  assign accept = mk_ok & ~brk_q & (mk[2] | dir_q[2] | (mk != {1'b0, ~dir_q[1], dir_q[0]}));
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    dir_d = dir_q;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      if (scan_code_q == 8'hE0) ext_d = 1'b1;
      else if (scan_code_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        dir_d = accept ? mk : dir_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q <= 1'b1;
      filt_cnt_q <= '0;
      fall_q <= 1'b0;
      state_q <= IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      par_ok_q <= 1'b0;
      to_cnt_q <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      scan_code_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      dir_q <= 3'b100;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      filt_q <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q <= filt_q & ~filt_d;
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      par_ok_q <= par_ok_d;
      to_cnt_q <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q <= frame_err_d;
      scan_code_q <= scan_code_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      dir_q <= dir_d;
    end
  assign direction_o = dir_q;
  assign scan_code_o = scan_code_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o = frame_err_q;
endmodule
